booth_mul_arbiter: RTL and testbench

Round-robin scheduler that shares one radix-4 Booth multiplier (`booth`, N=16) among NREQ requesters in the softmax datapath. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one multiply per cycle. Operands and products move through a stall-able register pipeline, and each product returns on a single tagged response channel. This lets several softmax lanes (exponent scaling, normalisation) use one multiplier instead of instantiating one per lane.

---
 rtl/softmax_pkg.sv | 26 ++
 rtl/booth.sv | 50 +++++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/booth_mul_arbiter.sv | 154 +++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/softmax_pkg.sv
// Shared softmax datapath definitions: multiplier width, request/response
// records and a small modulo helper used by the round-robin arbiter.
package softmax_pkg;

  localparam int BOOTH_N   = 16;
  localparam int MUL_TAG_W = 4;
  localparam int MUL_ID_W  = 3;

  typedef struct packed {
    logic [BOOTH_N-1:0]   a;
    logic [BOOTH_N-1:0]   b;
    logic [MUL_TAG_W-1:0] tag;
  } mul_req_t;

  typedef struct packed {
    logic [MUL_ID_W-1:0]    id;
    logic [MUL_TAG_W-1:0]   tag;
    logic [2*BOOTH_N-1:0]   res;
  } mul_rsp_t;

  // Wrap an index that is at most 2*n-1 back into 0..n-1.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/booth.sv
// Combinational radix-4 Booth multiplier, signed N x N -> 2N.
module booth
  import softmax_pkg::*;
#(
  parameter int N = BOOTH_N
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  localparam int NPP = N / 2;

  logic [N:0]     w_b_ext;
  logic [2*N-1:0] w_a_sx;
  logic [2*N-1:0] w_a_neg;
  logic [2*N-1:0] w_pp [NPP];

  assign w_b_ext = {i_b, 1'b0};
  assign w_a_sx  = {{N{i_a[N-1]}}, i_a};
  assign w_a_neg = -w_a_sx;

  generate
    for (genvar gi = 0; gi < NPP; gi++) begin : g_pp
      logic [2:0]     w_sel;
      logic [2*N-1:0] w_mag;
      assign w_sel = w_b_ext[2*gi +: 3];
      // Booth digit {-2,-1,0,+1,+2} times a, before positional shift.
      always_comb begin
        case (w_sel)
          3'b001, 3'b010: w_mag = w_a_sx;
          3'b011:         w_mag = w_a_sx << 1;
          3'b100:         w_mag = w_a_neg << 1;
          3'b101, 3'b110: w_mag = w_a_neg;
          default:        w_mag = '0;
        endcase
      end
      assign w_pp[gi] = w_mag << (2 * gi);
    end
  endgenerate

  // Partial-product accumulation; wrap-around at 2N bits yields the signed product.
  always_comb begin
    o_p = '0;
    for (int k = 0; k < NPP; k++) begin
      o_p = o_p + w_pp[k];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from the
// pointer; the pointer moves past the winner when the caller reports an accept.
module rr_arbiter
  import softmax_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_update,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_id
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;
  int             w_idx;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = rr_wrap(int'(r_ptr) + k, NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = IDW'(w_idx);
      end
    end
  end

  // Pointer advances to the slot after the accepted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_update) begin
      r_ptr <= IDW'(rr_wrap(int'(o_grant_id) + 1, NREQ));
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth multiplier among NREQ requesters with round-robin grant,
// an elastic A -> [M] -> R pipeline and one tagged response channel.
// Build option: define BOOTH_MUL_PIPE_EN to insert product stage M after booth.
module booth_mul_arbiter
  import softmax_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int N     = BOOTH_N,
  parameter int TAG_W = MUL_TAG_W,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [2*N-1:0]    rsp_res,
  output logic              busy
);

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_id;
  logic             w_accept;
  logic             w_r_load;
  logic             w_a_load;
  logic             w_a_adv;
  logic [2*N-1:0]   w_prod;

  logic             r_a_valid;
  logic [N-1:0]     r_a_a;
  logic [N-1:0]     r_a_b;
  logic [IDW-1:0]   r_a_id;
  logic [TAG_W-1:0] r_a_tag;

  logic             r_r_valid;
  logic [IDW-1:0]   r_r_id;
  logic [TAG_W-1:0] r_r_tag;
  logic [2*N-1:0]   r_r_res;

  logic             w_src_valid;
  logic [IDW-1:0]   w_src_id;
  logic [TAG_W-1:0] w_src_tag;
  logic [2*N-1:0]   w_src_res;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_valid),
    .i_update   (w_accept),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  booth #(.N(N)) u_booth (
    .i_a (r_a_a),
    .i_b (r_a_b),
    .o_p (w_prod)
  );

  // Grant is exposed only while A can take a new entry and reset is released.
  assign req_ready = w_grant & {NREQ{w_a_load & ~rst}};
  assign w_accept  = |req_ready;
  assign w_r_load  = ~r_r_valid | rsp_ready;
  assign w_a_load  = ~r_a_valid | w_a_adv;

`ifdef BOOTH_MUL_PIPE_EN
  logic             r_m_valid;
  logic [IDW-1:0]   r_m_id;
  logic [TAG_W-1:0] r_m_tag;
  logic [2*N-1:0]   r_m_res;
  logic             w_m_load;

  assign w_m_load    = ~r_m_valid | w_r_load;
  assign w_a_adv     = r_a_valid & w_m_load;
  assign w_src_valid = r_m_valid;
  assign w_src_id    = r_m_id;
  assign w_src_tag   = r_m_tag;
  assign w_src_res   = r_m_res;
  assign busy        = r_a_valid | r_m_valid | r_r_valid | (|req_valid);

  // Product stage: registers booth output so the multiplier has a full cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_id    <= '0;
      r_m_tag   <= '0;
      r_m_res   <= '0;
    end else if (w_m_load) begin
      r_m_valid <= r_a_valid;
      if (r_a_valid) begin
        r_m_id  <= r_a_id;
        r_m_tag <= r_a_tag;
        r_m_res <= w_prod;
      end
    end
  end
`else
  assign w_a_adv     = r_a_valid & w_r_load;
  assign w_src_valid = r_a_valid;
  assign w_src_id    = r_a_id;
  assign w_src_tag   = r_a_tag;
  assign w_src_res   = w_prod;
  assign busy        = r_a_valid | r_r_valid | (|req_valid);
`endif

  // Operand stage: captures the granted requester's operands on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_a     <= '0;
      r_a_b     <= '0;
      r_a_id    <= '0;
      r_a_tag   <= '0;
    end else if (w_a_load) begin
      r_a_valid <= w_accept;
      if (w_accept) begin
        r_a_a   <= req_a[int'(w_grant_id)*N +: N];
        r_a_b   <= req_b[int'(w_grant_id)*N +: N];
        r_a_id  <= w_grant_id;
        r_a_tag <= req_tag[int'(w_grant_id)*TAG_W +: TAG_W];
      end
    end
  end

  // Response stage: data only changes when a new valid entry lands, so the
  // outputs stay stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r_valid <= 1'b0;
      r_r_id    <= '0;
      r_r_tag   <= '0;
      r_r_res   <= '0;
    end else if (w_r_load) begin
      r_r_valid <= w_src_valid;
      if (w_src_valid) begin
        r_r_id  <= w_src_id;
        r_r_tag <= w_src_tag;
        r_r_res <= w_src_res;
      end
    end
  end

  assign rsp_valid = r_r_valid;
  assign rsp_id    = r_r_id;
  assign rsp_tag   = r_r_tag;
  assign rsp_res   = r_r_res;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: directed vector table, multi-cycle
// sequences (round-robin, backpressure, fairness, mid-operation reset) and a
// random run, all backed by a scoreboard on the response channel.
module tb_booth_mul_arbiter;

`ifdef BOOTH_MUL_PIPE_EN
  localparam int LAT = 3;
  localparam int CAP = 3;
`else
  localparam int LAT = 2;
  localparam int CAP = 2;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_res;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  booth_mul_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_res   (rsp_res),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_tag[i*4 +: 4] = t;
    req_valid[i]      = 1'b1;
  endtask

  // Scoreboard: expected responses queued at accept, compared at handshake.
  typedef struct packed {
    logic [1:0]  id;
    logic [3:0]  tag;
    logic [31:0] res;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_id",  64'(rsp_id),  64'(e.id));
          check("sb_tag", 64'(rsp_tag), 64'(e.tag));
          check("sb_res", 64'(rsp_res), 64'(e.res));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          logic signed [15:0] sa;
          logic signed [15:0] sb;
          logic signed [31:0] sp;
          sa = req_a[i*16 +: 16];
          sb = req_b[i*16 +: 16];
          sp = sa * sb;
          e.id  = 2'(i);
          e.tag = req_tag[i*4 +: 4];
          e.res = sp;
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic reset_pulse();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    req_valid = '0;
    rsp_ready = 1'b1;
    k = 0;
    while (busy && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    check({nm, "_idle"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gid, acc, total, k;
    bit have, got;
    logic [37:0] held;
    logic [3:0] accm;

    vecs[0] = '{2, 16'sd3,      -16'sd5,    4'h9, 32'hFFFFFFF1};
    vecs[1] = '{0, 16'h7FFF,    16'h7FFF,   4'h1, 32'h3FFF0001};
    vecs[2] = '{1, 16'h8000,    16'h8000,   4'h2, 32'h40000000};
    vecs[3] = '{3, 16'h8000,    16'h7FFF,   4'hF, 32'hC0008000};
    vecs[4] = '{0, 16'h0000,    16'hFFFF,   4'h3, 32'h00000000};
    vecs[5] = '{1, 16'hFFFF,    16'hFFFF,   4'h4, 32'h00000001};
    vecs[6] = '{3, 16'd1234,    -16'sd2,    4'hA, 32'hFFFFF65C};
    vecs[7] = '{2, 16'd100,     16'd100,    4'h7, 32'h00002710};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_rsp_tag",   64'(rsp_tag),   64'd0);
    check("rst_rsp_res",   64'(rsp_res),   64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    req_valid[0] = 1'b1;
    #1;
    check("rst_busy_req",  64'(busy),      64'd1);
    check("rst_ready_req", 64'(req_ready), 64'd0);
    reset_pulse();

    // Directed vector table: one request at a time, latency and result
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].tag);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!req_ready[vecs[v].id] && k < 20);
      check("vec_grant", 64'(req_ready[vecs[v].id]), 64'd1);
      @(posedge clk);
      #1 req_valid[vecs[v].id] = 1'b0;
      lat = 1;
      do begin
        @(posedge clk);
        #1 lat++;
      end while (!rsp_valid && lat < 20);
      check("vec_latency", 64'(lat), 64'(LAT));
      check("vec_id",  64'(rsp_id),  64'(vecs[v].id));
      check("vec_tag", 64'(rsp_tag), 64'(vecs[v].tag));
      check("vec_res", 64'(rsp_res), 64'(vecs[v].exp));
      $display("[TB] vec %0d id=%0d a=0x%04h b=0x%04h res=0x%08h lat=%0d",
               v, vecs[v].id, vecs[v].a, vecs[v].b, rsp_res, lat);
      @(posedge clk);
      #1;
    end
    drain("vec");

    // All requesters valid from reset: grants 0,1,2,3,0,... one per cycle
    rst = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 16'(i + 1), 16'd10, 4'(i + 4));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      gid = -1;
      for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
      check("rr_onehot", 64'($countones(req_ready)), 64'd1);
      check("rr_order", 64'(gid), 64'(c % 4));
      if (c >= LAT) check("rr_stream", 64'(rsp_valid), 64'd1);
      $display("[TB] rr cycle %0d grant=%0d rsp_valid=%0d", c, gid, rsp_valid);
    end
    @(posedge clk);
    #1 drain("rr");

    // Backpressure: rsp_ready low for 6 cycles
    reset_pulse();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 16'(100 * (i + 1)), -16'sd3, 4'(8 + i));
    acc  = 0;
    have = 1'b0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc += $countones(req_ready);
      if (rsp_valid) begin
        if (!have) begin
          held = {rsp_id, rsp_tag, rsp_res};
          have = 1'b1;
        end else begin
          check("bp_stable", 64'({rsp_id, rsp_tag, rsp_res}), 64'(held));
        end
      end
      if (c < 5) begin
        @(posedge clk);
        #1;
      end
    end
    check("bp_accepts", 64'(acc), 64'(CAP));
    check("bp_ready_zero", 64'(req_ready), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    $display("[TB] backpressure accepts=%0d held rsp=0x%0h", acc, held);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 drain("bp");

    // Fairness: requester 0 always valid, requester 3 asserts once
    reset_pulse();
    rsp_ready = 1'b1;
    set_req(0, 16'd7, 16'd9, 4'h1);
    set_req(3, 16'd11, 16'd13, 4'hC);
    acc = 0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 4'd0) acc++;
      if (req_ready[3]) got = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[3] = 1'b0;
    check("fair_granted", 64'(got), 64'd1);
    check("fair_within", 64'(acc <= 4), 64'd1);
    $display("[TB] fairness requester 3 granted after %0d accepts", acc);
    drain("fair");

    // Reset with two operations in flight
    reset_pulse();
    rsp_ready = 1'b0;
    set_req(1, 16'd5, 16'd6, 4'h5);
    set_req(2, 16'd7, 16'd8, 4'h6);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rsp_res",   64'(rsp_res),   64'd0);
    check("mid_rsp_id",    64'(rsp_id),    64'd0);
    check("mid_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_first_grant", 64'(req_ready), 64'b0010);
    check("mid_no_stale", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    check("mid_second_grant", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    $display("[TB] mid-operation reset sequence done");
    drain("mid");

    // Random operands with random response backpressure
    reset_pulse();
    total = 0;
    for (int cyc = 0; cyc < 60000 && total < 10000; cyc++) begin
      @(negedge clk);
      accm = req_valid & req_ready;
      total += $countones(accm);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (accm[i] || !req_valid[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            int ra, rb;
            ra = int'($urandom_range(0, 16382)) - 8191;
            rb = int'($urandom_range(0, 16382)) - 8191;
            set_req(i, 16'(ra), 16'(rb), 4'($urandom_range(0, 15)));
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    check("rand_count", 64'(total >= 10000), 64'd1);
    $display("[TB] random run accepts=%0d", total);
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
